// File: rtl/wb_trace_buffer.sv
// Writeback commit trace FIFO with HALT and no-commit watchdog detection; TRACE_FILTER_X0_EN drops rd==x0 commits.
// Latency: 1 cycle commit->rd_valid. Backpressure: rd_ready stalls the head; a full buffer drops commits and sets overflow.
module wb_trace_buffer #(
   parameter int XLEN           = 32,
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_valid,
   input  logic [XLEN-1:0]          wb_pc,
   input  logic [31:0]              wb_inst,
   input  logic [4:0]               wb_rd,
   input  logic [XLEN-1:0]          wb_data,
   input  logic                     halt_in,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [XLEN-1:0]          rd_pc,
   output logic [31:0]              rd_inst,
   output logic [4:0]               rd_rd,
   output logic [XLEN-1:0]          rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     halted,
   output logic                     timeout,
   output logic                     done
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_TIMEOUT} state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        wr_entry;
   entry_t        head;

   state_t        state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [WW-1:0] wdog_q, wdog_d;
   logic          overflow_q, overflow_d;

   logic          rd_ok;
   logic          cap;
   logic          pop;
   logic          full;
   logic          push_ok;

`ifdef TRACE_FILTER_X0_EN
   assign rd_ok = (wb_rd != 5'd0);
`else
   assign rd_ok = 1'b1;
`endif

   assign cap      = wb_valid && (wb_pc != '0) && rd_ok &&
                     ((state_q == S_IDLE) || (state_q == S_RUN));
   assign full     = (count_q == FULL_CNT);
   assign pop      = rd_valid && rd_ready;
   // When full, a same-cycle pop frees the head slot the write pointer aliases.
   assign push_ok  = cap && (!full || pop);

   assign wr_entry = '{pc: wb_pc, inst: wb_inst, rd: wb_rd, data: wb_data};
   assign head     = mem_q[rd_ptr_q];

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      wdog_d     = wdog_q;
      overflow_d = overflow_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop) begin
         count_d = count_q - 1'b1;
      end
      if (cap && !push_ok) begin
         overflow_d = 1'b1;
      end

      if ((state_q != S_RUN) || cap) begin
         wdog_d = '0;
      end else if (wdog_q != WD_LIMIT) begin
         wdog_d = wdog_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (halt_in) begin
               state_d = S_HALTED;
            end else if (cap) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (halt_in) begin
               state_d = S_HALTED;
            end else if (!cap && (wdog_q == WD_LIMIT)) begin
               state_d = S_TIMEOUT;
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         wdog_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         wdog_q     <= wdog_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately left out of reset; the pointers define what is live.
   always_ff @(posedge clk) begin
      if (rst && push_ok) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   assign rd_valid = (count_q != '0);
   assign rd_pc    = head.pc;
   assign rd_inst  = head.inst;
   assign rd_rd    = head.rd;
   assign rd_data  = head.data;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign halted   = (state_q == S_HALTED);
   assign timeout  = (state_q == S_TIMEOUT);
   assign done     = ((state_q == S_HALTED) || (state_q == S_TIMEOUT)) && (count_q == '0);

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer (DEPTH=4, TIMEOUT_CYCLES=8) with a queue-based reference model.
module tb_wb_trace_buffer;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [31:0] wb_pc;
   logic [31:0] wb_inst;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        halt_in;
   logic        rd_ready;
   logic        rd_valid;
   logic [31:0] rd_pc;
   logic [31:0] rd_inst;
   logic [4:0]  rd_rd;
   logic [31:0] rd_data;
   logic [2:0]  count;
   logic        overflow;
   logic        halted;
   logic        timeout;
   logic        done;

   always #5 clk = ~clk;

   wb_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_rd(wb_rd), .wb_data(wb_data),
      .halt_in(halt_in), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_rd(rd_rd), .rd_data(rd_data),
      .count(count), .overflow(overflow), .halted(halted), .timeout(timeout), .done(done)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of records plus a mode and the cycle of the last commit.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t mq[$];
   ent_t m_ent;
   bit   m_ok   = 0;
   bit   m_ovf  = 0;
   int   m_mode = 0;   // 0 idle, 1 run, 2 halted, 3 timeout
   int   m_cyc  = 0;
   int   m_last = 0;
   bit   m_cap, m_pop, m_fok;

   always @(posedge clk) begin
      if (!rst) begin
         mq.delete();
         m_ovf  = 0;
         m_mode = 0;
         m_ok   = 1;
      end else begin
`ifdef TRACE_FILTER_X0_EN
         m_fok = (wb_rd != 5'd0);
`else
         m_fok = 1'b1;
`endif
         m_cap = wb_valid && (wb_pc != 32'd0) && (m_mode < 2) && m_fok;
         m_pop = (mq.size() > 0) && rd_ready;
         if (m_pop) void'(mq.pop_front());
         if (m_cap) begin
            if (mq.size() < DEPTH) begin
               m_ent = '{pc: wb_pc, inst: wb_inst, rd: wb_rd, data: wb_data};
               mq.push_back(m_ent);
            end else begin
               m_ovf = 1;
            end
         end
         if (m_mode < 2 && halt_in) begin
            m_mode = 2;
         end else if (m_mode == 0 && m_cap) begin
            m_mode = 1;
            m_last = m_cyc;
         end else if (m_mode == 1) begin
            if (m_cap) m_last = m_cyc;
            else if (m_cyc - m_last == TMO) m_mode = 3;
         end
      end
      m_cyc++;
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
         if (mq.size() > 0) begin
            chk("rd_pc",   rd_pc,          mq[0].pc);
            chk("rd_inst", rd_inst,        mq[0].inst);
            chk("rd_rd",   32'(rd_rd),     32'(mq[0].rd));
            chk("rd_data", rd_data,        mq[0].data);
         end
         chk("count",    32'(count),    32'(mq.size()));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("halted",   32'(halted),   32'(m_mode == 2));
         chk("timeout",  32'(timeout),  32'(m_mode == 3));
         chk("done",     32'(done),     32'(m_mode >= 2 && mq.size() == 0));
      end
   end

   function automatic logic [4:0] rdof(input logic [31:0] pc);
      return pc[6:2] | 5'd1;
   endfunction

   task automatic cyc(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                      input logic h, input logic r);
      wb_valid = v;
      wb_pc    = pc;
      wb_inst  = pc ^ 32'h0000_0013;
      wb_rd    = rd;
      wb_data  = ~pc;
      halt_in  = h;
      rd_ready = r;
      @(negedge clk);
   endtask

   task automatic commit(input logic [31:0] pc, input logic h, input logic r);
      cyc(1'b1, pc, rdof(pc), h, r);
   endtask

   task automatic idle(input logic r);
      cyc(1'b0, 32'd0, 5'd0, 1'b0, r);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle(1'b0);
      idle(1'b0);
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_time_limit: got no finish, expected finish before 100us");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      wb_valid = 1'b0; wb_pc = '0; wb_inst = '0; wb_rd = '0; wb_data = '0;
      halt_in = 1'b0; rd_ready = 1'b0;
      @(negedge clk);

      // Basic capture and drain
      do_reset();
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_count",    32'(count),    32'd0);
      chk("rst_done",     32'(done),     32'd0);
      cyc(1'b1, 32'h0, 5'd1, 1'b0, 1'b0);
      chk("pc0_ignored", 32'(count), 32'd0);
      commit(32'h4, 1'b0, 1'b0);
      commit(32'h8, 1'b0, 1'b0);
      chk("basic_count", 32'(count), 32'd2);
      chk("basic_model_size", 32'(mq.size()), 32'd2);
      chk("basic_head0", rd_pc, 32'h4);
      idle(1'b1);
      chk("basic_head1", rd_pc, 32'h8);
      idle(1'b1);
      chk("basic_empty", 32'(rd_valid), 32'd0);

      // Overflow
      do_reset();
      for (int i = 0; i < 6; i++) commit(32'h100 + 32'(4 * i), 1'b0, 1'b0);
      chk("ovf_count", 32'(count), 32'd4);
      chk("ovf_flag",  32'(overflow), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_drain_pc", rd_pc, 32'h100 + 32'(4 * i));
         idle(1'b1);
      end
      chk("ovf_drained", 32'(rd_valid), 32'd0);
      chk("ovf_sticky",  32'(overflow), 32'd1);

      // Push and pop while full
      do_reset();
      for (int i = 0; i < 4; i++) commit(32'h200 + 32'(4 * i), 1'b0, 1'b0);
      chk("full_count", 32'(count), 32'd4);
      commit(32'h210, 1'b0, 1'b1);
      chk("pp_count", 32'(count), 32'd4);
      chk("pp_ovf",   32'(overflow), 32'd0);
      chk("pp_head",  rd_pc, 32'h204);
      for (int i = 0; i < 3; i++) idle(1'b1);
      chk("pp_tail", rd_pc, 32'h210);
      chk("pp_tail_count", 32'(count), 32'd1);

      // Halt with a same-cycle commit
      do_reset();
      commit(32'h3C, 1'b0, 1'b0);
      commit(32'h40, 1'b1, 1'b0);
      chk("halt_flag",  32'(halted), 32'd1);
      chk("halt_count", 32'(count), 32'd2);
      commit(32'h44, 1'b0, 1'b0);
      chk("halt_ignored", 32'(count), 32'd2);
      idle(1'b1);
      chk("halt_head", rd_pc, 32'h40);
      chk("halt_not_done", 32'(done), 32'd0);
      idle(1'b1);
      chk("halt_done", 32'(done), 32'd1);

      // Watchdog
      do_reset();
      commit(32'h500, 1'b0, 1'b0);
      repeat (7) idle(1'b0);
      chk("wd_before", 32'(timeout), 32'd0);
      idle(1'b0);
      chk("wd_fire", 32'(timeout), 32'd1);
      chk("wd_not_done", 32'(done), 32'd0);
      do_reset();
      commit(32'h500, 1'b0, 1'b0);
      repeat (6) idle(1'b0);
      commit(32'h504, 1'b0, 1'b0);
      repeat (7) idle(1'b0);
      chk("wd_rearm_quiet", 32'(timeout), 32'd0);
      idle(1'b0);
      chk("wd_rearm_fire", 32'(timeout), 32'd1);

      // Reset mid-run and x0 filter
      do_reset();
      for (int i = 0; i < 3; i++) commit(32'h600 + 32'(4 * i), 1'b0, 1'b0);
      chk("mid_count", 32'(count), 32'd3);
      rst = 1'b0;
      idle(1'b0);
      rst = 1'b1;
      chk("mid_rd_valid", 32'(rd_valid), 32'd0);
      chk("mid_count0",   32'(count),    32'd0);
      chk("mid_ovf",      32'(overflow), 32'd0);
      chk("mid_halted",   32'(halted),   32'd0);
      chk("mid_timeout",  32'(timeout),  32'd0);
      chk("mid_done",     32'(done),     32'd0);
      cyc(1'b1, 32'h700, 5'd0, 1'b0, 1'b0);
`ifdef TRACE_FILTER_X0_EN
      chk("x0_count", 32'(count), 32'd0);
      repeat (9) idle(1'b0);
      chk("x0_stays_idle", 32'(timeout), 32'd0);
`else
      chk("x0_count", 32'(count), 32'd1);
      repeat (9) idle(1'b0);
      chk("x0_runs", 32'(timeout), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Synthesizable writeback-commit trace capture for the 5-stage RV32IM pipeline. Records every retired instruction (PC, instruction word, destination register, writeback data) into a parametrised first-word-fall-through buffer, and detects HALT and a no-commit watchdog timeout in hardware. A valid/ready port drains the records. It sits beside `Processor` on its writeback trace outputs, and both on-chip debug logic and benches read from it.

## Interface
- `XLEN`, 32: width of the PC and writeback data fields.
- `DEPTH`, 16: number of trace entries; must be a power of two, minimum 2.
- `TIMEOUT_CYCLES`, 5000: number of consecutive RUN cycles without a captured commit before TIMEOUT; minimum 1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-low.
- `wb_valid`  in  1  a commit is present on the writeback trace this cycle.
- `wb_pc`  in  XLEN  PC of the committing instruction.
- `wb_inst`  in  32  committing instruction word.
- `wb_rd`  in  5  destination register index.
- `wb_data`  in  XLEN  writeback data.
- `halt_in`  in  1  processor halt flag (level).
- `rd_ready`  in  1  the consumer accepts the head entry.
- `rd_valid`  out  1  the buffer is non-empty and the head entry is presented.
- `rd_pc`, `rd_inst`, `rd_rd`, `rd_data`  out  XLEN/32/5/XLEN  head entry fields.
- `count`  out  $clog2(DEPTH)+1  number of entries stored.
- `overflow`  out  1  sticky flag: at least one commit was dropped because the buffer was full.
- `halted`  out  1  the state is HALTED.
- `timeout`  out  1  the state is TIMEOUT.
- `done`  out  1  the state is terminal (HALTED or TIMEOUT) and the buffer is empty.

## Operation
- States: IDLE, RUN, HALTED, TIMEOUT. Reset enters IDLE.
- Capture condition: `cap = wb_valid && wb_pc != 0 && state ∈ {IDLE, RUN}`, qualified further by the configuration filter.
- IDLE -> RUN on the first cycle `cap` is true; that commit is captured.
- IDLE or RUN -> HALTED on the first cycle `halt_in = 1`. A commit qualifying in that same cycle is still captured.
- RUN -> TIMEOUT when the watchdog reaches `TIMEOUT_CYCLES - 1` and no commit is captured in that cycle.
- `halt_in` takes priority over the timeout when both occur in the same cycle.
- HALTED and TIMEOUT are terminal until reset. Capture stops in these states; draining continues.
- Watchdog:
  - Clears to 0 on every captured commit and whenever the state is not RUN.
  - Otherwise increments by 1 per cycle and saturates.
  - The IDLE period is not counted.
- Push when `cap`. If the buffer is full and no pop happens in the same cycle, the entry is dropped, `overflow` is set and the buffer contents are unchanged.
- Pop when `rd_valid && rd_ready`.
- A simultaneous push and pop is legal at any occupancy, including full: `count` stays unchanged and no drop occurs.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `count` is tracked separately to distinguish full from empty.
- The `rd_*` fields are driven from the head entry and are don't-care when `rd_valid = 0`.

## Timing
- Reset (rst = 0 at a clock edge) sets: state = IDLE, pointers = 0, `count` = 0, `rd_valid` = 0, `overflow` = 0, `halted` = 0, `timeout` = 0, `done` = 0, watchdog = 0.
- Reset asserted mid-run discards all buffered entries in that cycle. The buffer storage itself is not cleared.
- Latency from a commit at edge N to `rd_valid` = 1 with that entry's fields on an empty buffer: 1 cycle, visible after edge N.
- `count`, `overflow`, `halted`, `timeout` and `done` are registered and update at the edge following their cause.
- Pop takes effect at the edge where `rd_valid && rd_ready` is sampled. The next entry appears after that edge with no bubble.
- `rd_valid` does not depend combinationally on `rd_ready`.

## Configuration
- `TRACE_FILTER_X0_EN` defined: commits with `wb_rd == 0` do not satisfy `cap`. They are not stored, do not clear the watchdog, and do not trigger IDLE -> RUN. This filters branches, stores and other commits with no register effect.
- `TRACE_FILTER_X0_EN` undefined: every commit with a non-zero PC is captured regardless of `wb_rd`.

## Test plan
- **Basic capture and drain:** reset, then 3 commits at PC 0x0, 0x4, 0x8 with `rd_ready = 0`. Required: `count` = 2 (the PC 0x0 commit is ignored) and the state stays IDLE until the PC 0x4 commit. Then set `rd_ready = 1`: the entries come out as 0x4 then 0x8, then `rd_valid` = 0.
- **Overflow:** with DEPTH = 4 and `rd_ready = 0`, send 6 commits. Required: `count` = 4, `overflow` = 1, and draining returns the first 4 PCs in order.
- **Push and pop while full:** with the buffer full, assert a commit and `rd_ready` in the same cycle. Required: `count` stays at 4, `overflow` stays 0, and the new entry becomes the tail.
- **Halt with a same-cycle commit:** assert `halt_in` together with the commit at PC 0x40. Required: 0x40 is captured, `halted` = 1 the next cycle, later commits are ignored, and `done` = 1 one cycle after the last pop.
- **Watchdog:** with TIMEOUT_CYCLES = 8, make one commit and then none. Required: `timeout` = 1 exactly 8 cycles after the commit edge. A variant with a commit at cycle 7 must reset the watchdog so that no timeout occurs.
- **Reset mid-run and filter:** assert rst = 0 with 3 entries stored. Required: all outputs return to their reset values the next cycle. With `TRACE_FILTER_X0_EN` defined, a commit with `wb_rd == 0` leaves `count` unchanged and the state in IDLE.
